ball_kinematics: RTL and testbench
==================================

# ball_kinematics

Per-ball motion stage that sits directly downstream of the collision/hit controller. It turns velocity overrides from collision detection, shot launches from the cue logic and hole events into a registered ball position and velocity. State is updated once per video frame. Friction, border clamping and ball-sinking are applied here, and the outputs feed the ball drawer and the next frame's collision checks.

## Interface
Parameters:
- INIT_X, 300: top-left X (pixels) after reset or respawn
- INIT_Y, 240: top-left Y (pixels) after reset or respawn
- X_MIN, 32 / X_MAX, 592: legal top-left X range (pixels, inclusive)
- Y_MIN, 32 / Y_MAX, 432: legal top-left Y range (pixels, inclusive)
- FRAC_BITS, 6: fractional bits of position; velocity unit is 1/2^FRAC_BITS px/frame
- MAX_VEL, 512: velocity magnitude saturation limit
- FRICTION_PERIOD, 4: frames between friction steps (≥1)
- FRICTION_STEP, 2: magnitude removed per friction step

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse, once per frame
- collisionOccurred  in  1  collision-detection override valid (combinational, may hold many cycles)
- velXIn, velYIn  in  11 signed  override velocity from collision detection
- shotValid  in  1  cue launch request, one-cycle pulse
- shotVelX, shotVelY  in  11 signed  launch velocity
- holeHit  in  1  ball overlaps any hole (level)
- respawn  in  1  one-cycle pulse, return sunk ball to INIT
- topLeftX, topLeftY  out  11 signed  integer ball position
- velX, velY  out  11 signed  current velocity
- moving  out  1  high in MOVING
- sunk  out  1  high in SUNK

## Operation
- Internal position: 11+FRAC_BITS signed fixed point per axis. The outputs topLeftX/Y are the position arithmetically shifted right by FRAC_BITS.
- FSM states: IDLE, MOVING, SUNK. Reset state is IDLE, position is INIT, velocity is 0, frictionCnt is 0, pending is clear.
- Collision latch: any cycle with collisionOccurred=1 and pending clear stores velXIn/velYIn and sets pending. The first collision in a frame wins; later ones are ignored until the next update.
- Shot latch: shotValid in IDLE stores the shot velocity, saturated to ±MAX_VEL, and sets shotPending. shotValid in MOVING or SUNK is ignored.
- Frame update happens on a cycle with startOfFrame=1. Priority is holeHit, then pending collision, then shotPending, then plain integration.
  - holeHit (IDLE or MOVING): go to SUNK; velocity becomes 0; position is held; pending flags clear.
  - Pending collision: velocity is replaced by the latched value (saturated), then integrated.
  - In IDLE with shotPending: velocity is loaded and the FSM goes to MOVING. Integration starts on the next update.
  - MOVING: pos += vel (sign-extended), applied per axis.
  - After the sum, clamp to [MIN, MAX] (scaled by 2^FRAC_BITS). If an axis clamps, that velocity component is negated.
  - Friction in MOVING: frictionCnt increments each update and wraps at FRICTION_PERIOD-1. On the wrap, each nonzero component's magnitude drops by FRICTION_STEP, saturating at 0 with no sign flip.
  - When both velocity components are 0 after the update, go to IDLE and reset frictionCnt to 0.
- SUNK: ignores collisions, shots and holeHit. On respawn: position returns to INIT, velocity becomes 0, go to IDLE.
- A collision in the same cycle as startOfFrame is not used by that update; it is latched for the next one.

## Timing
- All outputs are registered. A startOfFrame update is visible on the outputs on the following cycle, so latency is 1 clk.
- Pending flags clear on the update cycle.
- Reset asserted mid-frame forces the reset state immediately, regardless of clk.
- Simultaneous shotValid and startOfFrame in IDLE: the shot is latched and used at the next startOfFrame.
- Simultaneous respawn and startOfFrame in SUNK: respawn wins; the result is IDLE at INIT.

## Test plan
- Reset with INIT (300,240) → topLeftX=300, topLeftY=240, velX=velY=0, moving=0, sunk=0.
- Shot (64,0) in IDLE, then 3 frames with FRICTION_PERIOD large:
  - Frame 1 → MOVING, velX=64, X=300.
  - Frames 2 and 3 → X=301, then X=302.
- Friction: velX=3, FRICTION_STEP=2, period 1:
  - Next update → velX=1.
  - Following update → velX=0, the FSM goes to IDLE, moving=0.
- Collision override: while MOVING with vel (64,64), collisionOccurred holds (-64,32) for 10 cycles, followed by a second collision (5,5).
  - Next update → vel=(-64,32); the second collision is ignored.
- Border clamp: X=591, velX=+128, FRAC_BITS=6 → X=592, velX=-128.
- Sink and respawn: holeHit during MOVING at an update → sunk=1, vel=0, position held; later shots are ignored. respawn → (300,240), IDLE.

Source files
------------

// File: rtl/ball_kinematics_if.sv
// Request and status bundle between the collision/cue/hole logic and one
// ball's kinematics stage.
interface ball_kinematics_if;
    logic               startOfFrame;
    logic               collisionOccurred;
    logic signed [10:0] velXIn;
    logic signed [10:0] velYIn;
    logic               shotValid;
    logic signed [10:0] shotVelX;
    logic signed [10:0] shotVelY;
    logic               holeHit;
    logic               respawn;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic signed [10:0] velX;
    logic signed [10:0] velY;
    logic               moving;
    logic               sunk;

    modport master (
        output startOfFrame, collisionOccurred, velXIn, velYIn,
        output shotValid, shotVelX, shotVelY, holeHit, respawn,
        input  topLeftX, topLeftY, velX, velY, moving, sunk
    );

    modport slave (
        input  startOfFrame, collisionOccurred, velXIn, velYIn,
        input  shotValid, shotVelX, shotVelY, holeHit, respawn,
        output topLeftX, topLeftY, velX, velY, moving, sunk
    );
endinterface

// File: rtl/ball_kinematics.sv
// Per-ball motion stage: latches collision and shot requests, then once per
// frame integrates a fixed-point position with friction, border bounce and sinking.
module ball_kinematics #(
    parameter int INIT_X          = 300,
    parameter int INIT_Y          = 240,
    parameter int X_MIN           = 32,
    parameter int X_MAX           = 592,
    parameter int Y_MIN           = 32,
    parameter int Y_MAX           = 432,
    parameter int FRAC_BITS       = 6,
    parameter int MAX_VEL         = 512,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    ball_kinematics_if.slave bus
);
    localparam int PW    = 11 + FRAC_BITS;
    localparam int CW    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam int SCALE = 2 ** FRAC_BITS;

    localparam logic signed [PW-1:0] INIT_XF  = PW'(INIT_X * SCALE);
    localparam logic signed [PW-1:0] INIT_YF  = PW'(INIT_Y * SCALE);
    localparam logic signed [PW+1:0] X_LO     = (PW+2)'(X_MIN * SCALE);
    localparam logic signed [PW+1:0] X_HI     = (PW+2)'(X_MAX * SCALE);
    localparam logic signed [PW+1:0] Y_LO     = (PW+2)'(Y_MIN * SCALE);
    localparam logic signed [PW+1:0] Y_HI     = (PW+2)'(Y_MAX * SCALE);
    localparam logic signed [10:0]   VMAX     = 11'(MAX_VEL);
    localparam logic signed [10:0]   FSTEP    = 11'(FRICTION_STEP);
    localparam logic [CW-1:0]        CNT_LAST = CW'(FRICTION_PERIOD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, SUNK = 2'd2} state_t;

    function automatic logic signed [10:0] sat_vel(input logic signed [10:0] v);
        if (v > VMAX)       return VMAX;
        else if (v < -VMAX) return -VMAX;
        else                return v;
    endfunction

    function automatic logic signed [10:0] apply_friction(input logic signed [10:0] v);
        if (v > FSTEP)       return v - FSTEP;
        else if (v < -FSTEP) return v + FSTEP;
        else                 return 11'sd0;
    endfunction

    // Returns {velocity, position}; a clamped axis bounces off the border.
    function automatic logic [PW+10:0] step_axis(input logic signed [PW-1:0] pos,
                                                 input logic signed [10:0]   vel,
                                                 input logic signed [PW+1:0] lo,
                                                 input logic signed [PW+1:0] hi);
        logic signed [PW+1:0] sum;
        sum = {{2{pos[PW-1]}}, pos} + {{(PW-9){vel[10]}}, vel};
        if (sum > hi)      return {-vel, hi[PW-1:0]};
        else if (sum < lo) return {-vel, lo[PW-1:0]};
        else               return {vel, sum[PW-1:0]};
    endfunction

    state_t               state_r, state_s;
    logic signed [PW-1:0] posx_r, posy_r, posx_s, posy_s;
    logic signed [10:0]   velx_r, vely_r, velx_s, vely_s;
    logic signed [10:0]   colx_r, coly_r, colx_s, coly_s;
    logic signed [10:0]   shotx_r, shoty_r, shotx_s, shoty_s;
    logic                 col_pend_r, col_pend_s, shot_pend_r, shot_pend_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic                 moving_r, sunk_r, moving_s, sunk_s;
    logic signed [10:0]   vx_s, vy_s;
    logic [PW+10:0]       ax_s, ay_s;
    logic                 shot_take_s;

    // Next state and datapath: request latching plus the per-frame update
    always_comb begin
        state_s     = state_r;
        posx_s      = posx_r;
        posy_s      = posy_r;
        velx_s      = velx_r;
        vely_s      = vely_r;
        colx_s      = colx_r;
        coly_s      = coly_r;
        shotx_s     = shotx_r;
        shoty_s     = shoty_r;
        col_pend_s  = col_pend_r;
        shot_pend_s = shot_pend_r;
        cnt_s       = cnt_r;
        vx_s        = velx_r;
        vy_s        = vely_r;
        ax_s        = '0;
        ay_s        = '0;
        shot_take_s = 1'b0;
        case (state_r)
            IDLE, MOVING: begin
                if (bus.startOfFrame) begin
                    shot_pend_s = 1'b0;
                    if (bus.holeHit) begin
                        state_s = SUNK;
                        velx_s  = 11'sd0;
                        vely_s  = 11'sd0;
                        cnt_s   = '0;
                    end else if (col_pend_r || (state_r == MOVING)) begin
                        vx_s   = col_pend_r ? colx_r : velx_r;
                        vy_s   = col_pend_r ? coly_r : vely_r;
                        ax_s   = step_axis(posx_r, vx_s, X_LO, X_HI);
                        ay_s   = step_axis(posy_r, vy_s, Y_LO, Y_HI);
                        posx_s = ax_s[PW-1:0];
                        posy_s = ay_s[PW-1:0];
                        vx_s   = ax_s[PW+10:PW];
                        vy_s   = ay_s[PW+10:PW];
                        if (cnt_r == CNT_LAST) begin
                            cnt_s = '0;
                            vx_s  = apply_friction(vx_s);
                            vy_s  = apply_friction(vy_s);
                        end else begin
                            cnt_s = cnt_r + CW'(1);
                        end
                        velx_s = vx_s;
                        vely_s = vy_s;
                        if ((vx_s == 11'sd0) && (vy_s == 11'sd0)) begin
                            state_s = IDLE;
                            cnt_s   = '0;
                        end else begin
                            state_s = MOVING;
                        end
                    end else if (shot_pend_r) begin
                        velx_s  = shotx_r;
                        vely_s  = shoty_r;
                        state_s = MOVING;
                    end else begin
                        state_s = state_r;
                    end
                    // A collision seen with the frame strobe waits for the next update
                    if (bus.collisionOccurred && !bus.holeHit) begin
                        col_pend_s = 1'b1;
                        colx_s     = sat_vel(bus.velXIn);
                        coly_s     = sat_vel(bus.velYIn);
                    end else begin
                        col_pend_s = 1'b0;
                    end
                end else if (bus.collisionOccurred && !col_pend_r) begin
                    col_pend_s = 1'b1;
                    colx_s     = sat_vel(bus.velXIn);
                    coly_s     = sat_vel(bus.velYIn);
                end else begin
                    col_pend_s = col_pend_r;
                end
                shot_take_s = bus.shotValid && (state_r == IDLE) && (state_s == IDLE);
                shot_pend_s = shot_take_s ? 1'b1 : shot_pend_s;
                shotx_s     = shot_take_s ? sat_vel(bus.shotVelX) : shotx_s;
                shoty_s     = shot_take_s ? sat_vel(bus.shotVelY) : shoty_s;
            end
            SUNK: begin
                if (bus.respawn) begin
                    state_s     = IDLE;
                    posx_s      = INIT_XF;
                    posy_s      = INIT_YF;
                    velx_s      = 11'sd0;
                    vely_s      = 11'sd0;
                    cnt_s       = '0;
                    col_pend_s  = 1'b0;
                    shot_pend_s = 1'b0;
                end else begin
                    state_s = SUNK;
                end
            end
            default: begin
                state_s     = IDLE;
                velx_s      = 11'sd0;
                vely_s      = 11'sd0;
                cnt_s       = '0;
                col_pend_s  = 1'b0;
                shot_pend_s = 1'b0;
            end
        endcase
    end

    // Status flags decoded from the next state so they register with it
    always_comb begin
        case (state_s)
            MOVING:  begin moving_s = 1'b1; sunk_s = 1'b0; end
            SUNK:    begin moving_s = 1'b0; sunk_s = 1'b1; end
            default: begin moving_s = 1'b0; sunk_s = 1'b0; end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            posx_r      <= INIT_XF;
            posy_r      <= INIT_YF;
            velx_r      <= 11'sd0;
            vely_r      <= 11'sd0;
            colx_r      <= 11'sd0;
            coly_r      <= 11'sd0;
            shotx_r     <= 11'sd0;
            shoty_r     <= 11'sd0;
            col_pend_r  <= 1'b0;
            shot_pend_r <= 1'b0;
            cnt_r       <= '0;
            moving_r    <= 1'b0;
            sunk_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            posx_r      <= posx_s;
            posy_r      <= posy_s;
            velx_r      <= velx_s;
            vely_r      <= vely_s;
            colx_r      <= colx_s;
            coly_r      <= coly_s;
            shotx_r     <= shotx_s;
            shoty_r     <= shoty_s;
            col_pend_r  <= col_pend_s;
            shot_pend_r <= shot_pend_s;
            cnt_r       <= cnt_s;
            moving_r    <= moving_s;
            sunk_r      <= sunk_s;
        end
    end

    assign bus.topLeftX = posx_r[PW-1:FRAC_BITS];
    assign bus.topLeftY = posy_r[PW-1:FRAC_BITS];
    assign bus.velX     = velx_r;
    assign bus.velY     = vely_r;
    assign bus.moving   = moving_r;
    assign bus.sunk     = sunk_r;
endmodule

// File: tb/tb_ball_kinematics.sv
// Scoreboard bench for ball_kinematics: a behavioural model predicts the
// outputs after each frame update or respawn, and a monitor compares them.
module tb_ball_kinematics;
    localparam int S    = 64;
    localparam int FP   = 4;
    localparam int STEP = 2;
    localparam int VM   = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ball_kinematics_if bus ();
    ball_kinematics dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {int x; int y; int vx; int vy; int mv; int sk;} exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // stimulus for the next cycle
    bit i_sof, i_col, i_shot, i_hole, i_resp;
    int i_cvx, i_cvy, i_svx, i_svy;

    // model state: 0 idle, 1 moving, 2 sunk
    int m_px, m_py, m_vx, m_vy, m_st, m_cnt;
    int m_cvx, m_cvy, m_svx, m_svy;
    bit m_pend, m_spend;
    logic ev_q;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > VM) ? VM : ((v < -VM) ? -VM : v);
    endfunction

    function automatic int slow(input int v);
        int mag;
        mag = ((v < 0) ? -v : v) - STEP;
        if (mag < 0) mag = 0;
        return (v < 0) ? -mag : mag;
    endfunction

    task automatic model_reset();
        m_px = 300 * S; m_py = 240 * S; m_vx = 0; m_vy = 0; m_st = 0; m_cnt = 0;
        m_cvx = 0; m_cvy = 0; m_svx = 0; m_svy = 0; m_pend = 0; m_spend = 0;
    endtask

    task automatic model_cycle();
        bit was_idle, had_pend, had_spend;
        was_idle  = (m_st == 0);
        had_pend  = m_pend;
        had_spend = m_spend;
        if (m_st == 2) begin
            if (i_resp) begin
                m_px = 300 * S; m_py = 240 * S; m_vx = 0; m_vy = 0; m_st = 0; m_cnt = 0;
            end
        end else if (i_sof) begin
            m_pend = 0; m_spend = 0;
            if (i_hole) begin
                m_st = 2; m_vx = 0; m_vy = 0; m_cnt = 0;
            end else if (had_pend || m_st == 1) begin
                if (had_pend) begin m_vx = m_cvx; m_vy = m_cvy; end
                m_px += m_vx; m_py += m_vy;
                if (m_px > 592 * S) begin m_px = 592 * S; m_vx = -m_vx; end
                if (m_px < 32 * S)  begin m_px = 32 * S;  m_vx = -m_vx; end
                if (m_py > 432 * S) begin m_py = 432 * S; m_vy = -m_vy; end
                if (m_py < 32 * S)  begin m_py = 32 * S;  m_vy = -m_vy; end
                m_cnt++;
                if (m_cnt == FP) begin m_cnt = 0; m_vx = slow(m_vx); m_vy = slow(m_vy); end
                if (m_vx == 0 && m_vy == 0) begin m_st = 0; m_cnt = 0; end
                else m_st = 1;
            end else if (had_spend) begin
                m_vx = m_svx; m_vy = m_svy; m_st = 1;
            end
            if (i_col && !i_hole) begin m_cvx = sat(i_cvx); m_cvy = sat(i_cvy); m_pend = 1; end
        end else if (i_col && !m_pend) begin
            m_cvx = sat(i_cvx); m_cvy = sat(i_cvy); m_pend = 1;
        end
        if (i_shot && was_idle && m_st == 0) begin
            m_svx = sat(i_svx); m_svy = sat(i_svy); m_spend = 1;
        end
    endtask

    task automatic drive_bus();
        bus.startOfFrame      = i_sof;
        bus.collisionOccurred = i_col;
        bus.velXIn            = 11'(i_cvx);
        bus.velYIn            = 11'(i_cvy);
        bus.shotValid         = i_shot;
        bus.shotVelX          = 11'(i_svx);
        bus.shotVelY          = 11'(i_svy);
        bus.holeHit           = i_hole;
        bus.respawn           = i_resp;
    endtask

    task automatic clear_inputs();
        i_sof = 0; i_col = 0; i_shot = 0; i_hole = 0; i_resp = 0;
        i_cvx = 0; i_cvy = 0; i_svx = 0; i_svy = 0;
    endtask

    task automatic step();
        exp_t e;
        drive_bus();
        model_cycle();
        if (i_sof || i_resp) begin
            e.x = m_px >>> 6; e.y = m_py >>> 6; e.vx = m_vx; e.vy = m_vy;
            e.mv = (m_st == 1) ? 1 : 0; e.sk = (m_st == 2) ? 1 : 0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic frame();
        i_sof = 1; step(); idle(2);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_x"}, int'(bus.topLeftX), 300);
        check({tag, "_y"}, int'(bus.topLeftY), 240);
        check({tag, "_vx"}, int'(bus.velX), 0);
        check({tag, "_vy"}, int'(bus.velY), 0);
        check({tag, "_moving"}, int'(bus.moving), 0);
        check({tag, "_sunk"}, int'(bus.sunk), 0);
    endtask

    function automatic int rnd_vel();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 2047)) - 1024;
        else return int'($urandom_range(0, 400)) - 200;
    endfunction

    // Records whether the last edge carried an output-changing event
    always @(posedge clk or posedge reset) begin
        if (reset) ev_q <= 1'b0;
        else       ev_q <= bus.startOfFrame | bus.respawn;
    end

    // Monitor: compares DUT outputs against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (ev_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("topLeftX", int'(bus.topLeftX), e.x);
                check("topLeftY", int'(bus.topLeftY), e.y);
                check("velX", int'(bus.velX), e.vx);
                check("velY", int'(bus.velY), e.vy);
                check("moving", int'(bus.moving), e.mv);
                check("sunk", int'(bus.sunk), e.sk);
            end
        end
    end

    initial begin
        clear_inputs();
        drive_bus();
        model_reset();
        repeat (2) @(negedge clk);
        check_init("reset");
        reset = 1'b0;
        @(negedge clk);

        // shot launch then straight-line motion
        i_shot = 1; i_svx = 64; step();
        idle(2);
        repeat (3) frame();

        // collision override held for many cycles, later one ignored
        i_col = 1; i_cvx = 64; i_cvy = 64; step();
        frame();
        for (int k = 0; k < 10; k++) begin i_col = 1; i_cvx = -64; i_cvy = 32; step(); end
        for (int k = 0; k < 3; k++) begin i_col = 1; i_cvx = 5; i_cvy = 5; step(); end
        frame();
        frame();
        i_col = 1; step();
        frame();

        // slow shot decays to rest under friction
        i_shot = 1; i_svx = 3; step();
        repeat (10) frame();

        // shot coincident with frame strobe is used one frame later
        i_shot = 1; i_svx = 512; i_svy = 512; i_sof = 1; step();
        frame();
        repeat (60) frame();
        i_col = 1; step();
        frame();

        // sink while moving, ignored requests, then respawn
        i_shot = 1; i_svx = 100; i_svy = -50; step();
        frame(); frame();
        i_hole = 1; i_sof = 1; step();
        i_shot = 1; i_svx = 40; step();
        i_col = 1; i_cvx = 30; step();
        frame();
        i_resp = 1; step();
        frame();

        // respawn coincident with frame strobe while sunk
        i_shot = 1; i_svx = -80; step();
        frame();
        i_hole = 1; i_sof = 1; step();
        i_resp = 1; i_sof = 1; i_hole = 1; step();
        frame();

        // asynchronous reset between clock edges
        i_shot = 1; i_svx = 200; i_svy = 100; step();
        frame(); frame();
        i_col = 1; i_cvx = 9; step();
        drive_bus();
        #2 reset = 1'b1;
        #1 check_init("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        frame();

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            i_sof  = ($urandom_range(0, 5) == 0);
            i_col  = ($urandom_range(0, 9) == 0);
            i_cvx  = rnd_vel();
            i_cvy  = rnd_vel();
            i_shot = ($urandom_range(0, 14) == 0);
            i_svx  = rnd_vel();
            i_svy  = rnd_vel();
            i_hole = ($urandom_range(0, 29) == 0);
            i_resp = ($urandom_range(0, 19) == 0);
            step();
        end
        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
